// File: rtl/lane_mem_arbiter_pkg.sv
// Shared types and the round-robin pick function for lane_mem_arbiter.
package lane_mem_arbiter_pkg;

    typedef enum logic [1:0] {INIT, IDLE, SERVE} arb_state_t;

    localparam int unsigned RR_MAX = 8;

    // One-hot grant: first set bit of valid searching upward from ptr, wrapping modulo n.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                  input int unsigned ptr,
                                                  input int unsigned n);
        logic [RR_MAX-1:0] g;
        logic              found;
        int unsigned       idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (!found && valid[idx[$clog2(RR_MAX)-1:0]]) begin
                    g[idx[$clog2(RR_MAX)-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/lane_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant plus the rotating priority pointer.
module rr_arbiter
    import lane_mem_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;

    always_comb begin
        grant    = NREQ'(rr_pick(RR_MAX'(valid), 32'(rr_ptr), NREQ));
        next_ptr = rr_ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) next_ptr = PW'((i + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/lane_mem_arbiter.sv
// Round-robin shared single-port memory with lane-granular writes and 1-cycle reads.
// MEMARB_ZERO_INIT_EN: zero every word after reset before accepting requests.
module lane_mem_arbiter
    import lane_mem_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ  = 3,
    parameter  int unsigned W     = 32,
    parameter  int unsigned LW    = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned NL    = W / LW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][NL-1:0]  req_lanes,
    input  logic [NREQ-1:0][W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [W-1:0]             rsp_rdata,
    output logic                     busy
);

    if (W % LW != 0) begin : g_lane_check
        $error("lane_mem_arbiter: W must be a multiple of LW");
    end

    arb_state_t      state;
    logic            in_init;
    logic [NREQ-1:0] arb_valid;
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [NL-1:0]   sel_lanes;
    logic [W-1:0]    sel_wdata;
    logic [W-1:0]    mem [0:DEPTH-1];
`ifdef MEMARB_ZERO_INIT_EN
    logic [AW-1:0]   init_addr;
`endif

    assign in_init = (state == INIT);
    // Masking with rst makes req_ready (and thus any write) drop asynchronously.
    assign arb_valid = req_valid & {NREQ{~rst & ~in_init}};

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .valid (arb_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign busy      = in_init | (~rst & |(req_valid & ~req_ready));

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_lanes = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i];
                sel_lanes = req_lanes[i];
                sel_wdata = req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef MEMARB_ZERO_INIT_EN
            state     <= INIT;
            init_addr <= '0;
`else
            state     <= IDLE;
`endif
        end else begin
            case (state)
                INIT: begin
`ifdef MEMARB_ZERO_INIT_EN
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == AW'(DEPTH - 1)) state <= IDLE;
`else
                    state <= IDLE;
`endif
                end
                IDLE, SERVE: state <= (|req_valid) ? SERVE : IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifdef MEMARB_ZERO_INIT_EN
        if (in_init && !rst) begin
            mem[init_addr] <= '0;
        end else
`endif
        if (any_grant && sel_we) begin
            for (int unsigned l = 0; l < NL; l++) begin
                if (sel_lanes[l]) mem[sel_addr][l*LW +: LW] <= sel_wdata[l*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (any_grant && !sel_we) ? grant : '0;
            if (any_grant && !sel_we) rsp_rdata <= mem[sel_addr];
        end
    end

endmodule

// File: tb/tb_lane_mem_arbiter.sv
// Self-checking bench for lane_mem_arbiter against a word-array reference model.
module tb_lane_mem_arbiter;

    localparam int NREQ  = 3;
    localparam int W     = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           req_valid;
    logic [2:0]           req_ready;
    logic [2:0]           req_we;
    logic [2:0][3:0]      req_addr;
    logic [2:0][3:0]      req_lanes;
    logic [2:0][31:0]     req_wdata;
    logic [2:0]           rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 busy;

    lane_mem_arbiter #(.NREQ(NREQ), .W(W), .LW(LW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_lanes (req_lanes),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];
    int          mptr;
    logic [2:0]  exp_rv;
    logic [31:0] exp_rd;
    logic [2:0]  obs_grant;
    logic [2:0]  obs_rv;
    logic [2:0]  fair_exp [6];
    logic [2:0]  fair_obs [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Entered at posedge+1; checks mid-cycle, advances the model, returns at next posedge+1.
    task automatic tick();
        int         g;
        logic [2:0] eg;
        @(negedge clk);
        obs_grant = req_ready;
        obs_rv    = rsp_valid;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        g  = pick(req_valid, mptr);
        eg = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("busy", 32'(busy), 32'(|(req_valid & ~eg)));
        exp_rv = 3'b000;
        if (g >= 0) begin
            if (req_we[g]) begin
                for (int l = 0; l < W / LW; l++) begin
                    if (req_lanes[g][l]) model_mem[req_addr[g]][l*LW +: LW] = req_wdata[g][l*LW +: LW];
                end
            end else begin
                exp_rv = eg;
                exp_rd = model_mem[req_addr[g]];
            end
            mptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input int r, input logic we, input logic [3:0] a,
                       input logic [3:0] l, input logic [31:0] d);
        req_valid    = 3'b000;
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r]  = a;
        req_lanes[r] = l;
        req_wdata[r] = d;
        tick();
    endtask

    task automatic idle();
        req_valid = 3'b000;
        tick();
    endtask

    task automatic model_reset();
        mptr   = 0;
        exp_rv = 3'b000;
        exp_rd = 32'h0;
    endtask

    // With zero-init, requests are refused for DEPTH cycles while memory clears.
    task automatic init_phase();
`ifdef MEMARB_ZERO_INIT_EN
        req_valid = 3'b111;
        req_we    = 3'b000;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            chk("init_ready", 32'(req_ready), 32'h0);
            chk("init_busy", 32'(busy), 32'h1);
            chk("init_rsp", 32'(rsp_valid), 32'h0);
            @(posedge clk);
            #1;
        end
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'h0;
        req_valid = 3'b000;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]      cv;
        logic [2:0]      cwe;
        logic [2:0][3:0] ca;
        logic [2:0][3:0] cl;
        logic [2:0][31:0] cwd;

        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst       = 1'b1;
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_addr  = '0;
        req_lanes = '0;
        req_wdata = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        req_valid = 3'b000;
        #1;
`ifdef MEMARB_ZERO_INIT_EN
        chk("reset_busy", 32'(busy), 32'h1);
`else
        chk("reset_busy", 32'(busy), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_phase();

`ifdef MEMARB_ZERO_INIT_EN
        for (int a = 0; a < DEPTH; a++) one(a % NREQ, 1'b0, 4'(a), 4'h0, 32'h0);
        idle();
        chk("init_last_rdata", rsp_rdata, 32'h0);
`else
        for (int a = 0; a < DEPTH; a++) one(0, 1'b1, 4'(a), 4'hF, $urandom);
`endif

        // basic write then read
        one(0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        one(0, 1'b0, 4'd3, 4'h0, 32'h0);
        idle();
        chk("basic_rsp_valid", 32'(obs_rv), 32'h1);
        chk("basic_rdata", rsp_rdata, 32'hDEADBEEF);

        // partial lane write
        one(1, 1'b1, 4'd5, 4'hF, 32'h11223344);
        one(2, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD);
        one(0, 1'b1, 4'd5, 4'h0, 32'hFFFFFFFF);
        one(1, 1'b0, 4'd5, 4'h0, 32'h0);
        idle();
        chk("partial_rdata", rsp_rdata, 32'h11BB33DD);

        // fairness: park the pointer at 0, then all three read continuously
        one(2, 1'b0, 4'd0, 4'h0, 32'h0);
        req_valid = 3'b111;
        req_we    = 3'b000;
        req_addr  = {4'd9, 4'd8, 4'd7};
        for (int c = 0; c < 6; c++) begin
            tick();
            fair_obs[c] = obs_grant;
        end
        for (int c = 0; c < 6; c++) chk("fair_grant", 32'(fair_obs[c]), 32'(fair_exp[c]));
        idle();

        // pointer wrap: park at 2, then 011 must go to requester 0, then 1
        one(1, 1'b0, 4'd1, 4'h0, 32'h0);
        req_valid = 3'b011;
        req_we    = 3'b000;
        tick();
        chk("wrap_grant", 32'(obs_grant), 32'h1);
        tick();
        chk("wrap_next", 32'(obs_grant), 32'h2);
        idle();

        // randomized traffic, payload held until granted
        cv = 3'b000; cwe = '0; ca = '0; cl = '0; cwd = '0;
        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!cv[r] || obs_grant[r]) begin
                    cv[r]  = ($urandom % 4) != 0;
                    cwe[r] = $urandom_range(0, 1);
                    ca[r]  = 4'($urandom);
                    cl[r]  = 4'($urandom);
                    cwd[r] = $urandom;
                end
            end
            req_valid = cv;
            req_we    = cwe;
            req_addr  = ca;
            req_lanes = cl;
            req_wdata = cwd;
            tick();
        end
        idle();

        // reset while a read response is on the bus
        one(0, 1'b1, 4'd3, 4'hF, 32'hCAFEF00D);
        one(0, 1'b0, 4'd3, 4'h0, 32'h0);
        req_valid = 3'b111;
        req_we    = 3'b000;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        model_reset();
        req_valid = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_phase();
        one(0, 1'b0, 4'd3, 4'h0, 32'h0);
        idle();
`ifdef MEMARB_ZERO_INIT_EN
        chk("postrst_rdata", rsp_rdata, 32'h0);
`else
        chk("postrst_rdata", rsp_rdata, 32'hCAFEF00D);
`endif
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
